// File: rtl/aes_pkg.sv
// Shared AES definitions: key/word widths, round count, FSM states, RCON and word helpers.
package aes_pkg;

    localparam int unsigned AES_KEY_W  = 128;
    localparam int unsigned AES_WORD_W = 32;
    localparam int unsigned AES128_NR  = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    // Round constant for expanding key i into key i+1; indices past 9 never reach the datapath.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    function automatic logic [AES_WORD_W-1:0] rot_word(input logic [AES_WORD_W-1:0] w);
        rot_word = {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box (forward), one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [7:0] SBOX_TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    always_comb begin
        out_byte = SBOX_TABLE[in_byte];
    end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: loads a cipher key, then emits round keys 0..NUM_ROUNDS
// over a valid/ready handshake, deriving each key from the previous one.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = AES128_NR
) (
    input  logic         clk,
    input  logic         g_rst,
    input  logic         start,
    input  logic [127:0] cipher_key,
    input  logic         key_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);

    state_e                 state_q, state_d;
    logic [AES_KEY_W-1:0]   key_q, key_d;
    logic [3:0]             idx_q, idx_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [AES_WORD_W-1:0]  w0, w1, w2, w3, w4, w5, w6, w7;
    logic [AES_WORD_W-1:0]  rot_w3, sub_w3, t_word;
    logic [AES_KEY_W-1:0]   next_key;

    // SubWord(RotWord(w3)) built from four byte-wide S-boxes.
    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .in_byte  (rot_w3[8*b +: 8]),
            .out_byte (sub_w3[8*b +: 8])
        );
    end

    always_comb begin
        {w0, w1, w2, w3} = key_q;
        rot_w3   = rot_word(w3);
        t_word   = sub_w3 ^ {rcon(idx_q), 24'h000000};
        w4       = w0 ^ t_word;
        w5       = w1 ^ w4;
        w6       = w2 ^ w5;
        w7       = w3 ^ w6;
        next_key = {w4, w5, w6, w7};
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = cipher_key;
                    idx_d   = 4'd0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = GEN;
                end
            end
            GEN: begin
                if (valid_q && key_ready) begin
                    if (idx_q == 4'(NUM_ROUNDS)) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        key_d = next_key;
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (g_rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= 4'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign round_key = key_q;
    assign round_idx = idx_q;
    assign key_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: an independent GF(2^8) key-schedule model fills a
// scoreboard queue at each start; round keys are popped and compared on every handshake.
module tb_aes_key_expand;

    localparam int unsigned NR = 10;

    logic         clk;
    logic         g_rst;
    logic         start;
    logic [127:0] cipher_key;
    logic         key_ready;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         busy;
    logic         done;

    int n_pass;
    int n_total;

    logic [131:0] sb[$];
    logic [127:0] got[11];
    logic [127:0] last_key;

    aes_key_expand #(.NUM_ROUNDS(NR)) dut (
        .clk        (clk),
        .g_rst      (g_rst),
        .start      (start),
        .cipher_key (cipher_key),
        .key_ready  (key_ready),
        .round_key  (round_key),
        .round_idx  (round_idx),
        .key_valid  (key_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    // S-box derived from first principles: multiplicative inverse then affine map.
    function automatic logic [7:0] sbox_m(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        if (x != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
            end
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] expand_m(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, r, t;
        {w0, w1, w2, w3} = k;
        r = {w3[23:16], w3[15:8], w3[7:0], w3[31:24]};
        t = {sbox_m(r[31:24]) ^ rc, sbox_m(r[23:16]), sbox_m(r[15:8]), sbox_m(r[7:0])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_schedule(input logic [127:0] key);
        logic [7:0]   rc_tab[10];
        logic [127:0] k;
        rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        k = key;
        for (int i = 0; i <= int'(NR); i++) begin
            sb.push_back({4'(i), k});
            if (i < int'(NR)) k = expand_m(k, rc_tab[i]);
        end
    endtask

    // mode 0: key_ready always high; mode 1: key_ready pattern 1,0,0,1.
    // glitch: pulse start with a different key while in GEN. abort_at >= 0: reset after that many accepts.
    task automatic run_sched(input logic [127:0] key, input int mode, input bit glitch, input int abort_at);
        int          accepts;
        int          cyc;
        int          pat[4];
        logic [131:0] exp;
        pat     = '{1, 0, 0, 1};
        accepts = 0;
        cyc     = 0;
        sb.delete();
        cipher_key = key;
        start      = 1'b1;
        push_schedule(key);
        step();
        start      = 1'b0;
        cipher_key = ~key;
        check("valid_after_start", 128'(key_valid), 128'(1));
        check("busy_after_start", 128'(busy), 128'(1));
        while (sb.size() > 0 && cyc < 200) begin
            if (abort_at == accepts) begin
                key_ready = 1'b1;
                g_rst     = 1'b1;
                step();
                g_rst = 1'b0;
                check("rst_round_key", round_key, 128'(0));
                check("rst_round_idx", 128'(round_idx), 128'(0));
                check("rst_key_valid", 128'(key_valid), 128'(0));
                check("rst_busy", 128'(busy), 128'(0));
                check("rst_done", 128'(done), 128'(0));
                step();
                check("rst_no_done", 128'(done), 128'(0));
                check("rst_stays_idle", 128'(busy), 128'(0));
                sb.delete();
                return;
            end
            key_ready = (mode == 0) ? 1'b1 : 1'(pat[cyc % 4]);
            start     = glitch && (cyc == 3);
            exp       = sb[0];
            check("gen_valid", 128'(key_valid), 128'(1));
            check("gen_busy", 128'(busy), 128'(1));
            check("gen_idx", 128'(round_idx), 128'(exp[131:128]));
            check("gen_key", round_key, exp[127:0]);
            if (key_valid && key_ready) begin
                got[exp[131:128]] = round_key;
                last_key          = exp[127:0];
                void'(sb.pop_front());
                accepts++;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        check("sched_timeout_left", 128'(sb.size()), 128'(0));
        check("accept_count", 128'(accepts), 128'(NR + 1));
        check("fin_done", 128'(done), 128'(1));
        check("fin_valid", 128'(key_valid), 128'(0));
        check("fin_busy", 128'(busy), 128'(1));
        step();
        check("idle_done", 128'(done), 128'(0));
        check("idle_busy", 128'(busy), 128'(0));
        check("idle_hold_idx", 128'(round_idx), 128'(NR));
        check("idle_hold_key", round_key, last_key);
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        g_rst      = 1'b1;
        start      = 1'b0;
        cipher_key = '0;
        key_ready  = 1'b0;
        last_key   = '0;
        step();
        step();
        check("reset_round_key", round_key, 128'(0));
        check("reset_round_idx", 128'(round_idx), 128'(0));
        check("reset_key_valid", 128'(key_valid), 128'(0));
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_done", 128'(done), 128'(0));
        g_rst = 1'b0;
        step();

        // FIPS-197 A.1 with key_ready held high
        run_sched(128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 1'b0, -1);
        check("fips_idx1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("fips_idx10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // zero key
        run_sched(128'h0, 0, 1'b0, -1);
        check("zero_idx0", got[0], 128'h0);
        check("zero_idx1", got[1], 128'h62636363626363636263636362636363);

        // backpressure
        run_sched(128'h2b7e151628aed2a6abf7158809cf4f3c, 1, 1'b0, -1);
        check("bp_idx10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // start during GEN is ignored
        run_sched(128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 1'b1, -1);
        check("glitch_idx1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("glitch_idx10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // reset at idx 5, then a clean restart
        run_sched(128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 1'b0, 5);
        run_sched(128'h000102030405060708090a0b0c0d0e0f, 0, 1'b0, -1);
        check("restart_idx0", got[0], 128'h000102030405060708090a0b0c0d0e0f);
        check("restart_idx10", got[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // back-to-back: start in the first IDLE cycle after done
        run_sched(128'h0, 1, 1'b0, -1);
        run_sched(128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 1'b0, -1);
        check("b2b_idx1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
